// File: rtl/calc1_pkg.sv
// Shared constants, FSM state type and command check for the calc1 port driver.
package calc1_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE    = 2'd0;
  localparam logic [1:0] RESP_OK      = 2'd1;
  localparam logic [1:0] RESP_ERR     = 2'd2;
  localparam logic [1:0] RESP_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT
  } drv_state_t;

  function automatic logic cmd_is_valid(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc1_op_fifo.sv
// Synchronous op queue; pointers carry an extra wrap bit so full and empty are distinguishable.
module calc1_op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; a push while full is only ever issued together with a pop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/calc1_port_driver.sv
// Upstream request stage for one calc1 port: queue, two-cycle cmd/data send, response wait, result.
// Define CALC1_DRV_CMD_FILTER_EN to reject commands outside {ADD,SUB,SHL,SHR} locally.
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 1
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_cmd,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic [TAG_W-1:0] op_tag,
  output logic [3:0]       req_cmd_out,
  output logic [31:0]      req_data_out,
  input  logic [1:0]       out_resp,
  input  logic [31:0]      out_data,
  output logic             res_valid,
  output logic [1:0]       res_resp,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             err_spurious
);

  localparam int OP_W   = 4 + 32 + 32 + TAG_W;
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYC);

  drv_state_t        state, state_n;
  logic [OP_W-1:0]   head;
  logic              fifo_full, fifo_empty;
  logic              push, pop, reject;
  logic              resp_seen, timeout_hit;
  logic [3:0]        head_cmd, cur_cmd;
  logic [31:0]       head_a, head_b, cur_a, cur_b;
  logic [TAG_W-1:0]  head_tag, cur_tag;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  assign {head_cmd, head_a, head_b, head_tag} = head;
  // A pop frees a slot in the same cycle, so a full queue may still accept.
  assign op_ready    = !fifo_full || pop;
  assign push        = op_valid && op_ready;
  assign resp_seen   = (out_resp != RESP_NONE);
  assign timeout_hit = (wait_cnt == WAIT_LAST);

  calc1_op_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OP_W)
  ) u_fifo (
    .clk     (c_clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data ({op_cmd, op_a, op_b, op_tag}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    reject       = 1'b0;
    req_cmd_out  = CMD_NOP;
    req_data_out = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && gap_cnt == '0) begin
          pop = 1'b1;
`ifdef CALC1_DRV_CMD_FILTER_EN
          if (cmd_is_valid(head_cmd)) state_n = ST_SEND_A;
          else                        reject  = 1'b1;
`else
          state_n = ST_SEND_A;
`endif
        end
      end
      ST_SEND_A: begin
        req_cmd_out  = cur_cmd;
        req_data_out = cur_a;
        state_n      = ST_SEND_B;
      end
      ST_SEND_B: begin
        req_data_out = cur_b;
        state_n      = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_seen || timeout_hit) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      gap_cnt      <= '0;
      cur_cmd      <= '0;
      cur_a        <= '0;
      cur_b        <= '0;
      cur_tag      <= '0;
      res_valid    <= 1'b0;
      res_resp     <= RESP_NONE;
      res_data     <= '0;
      res_tag      <= '0;
      err_spurious <= 1'b0;
    end else begin
      state     <= state_n;
      res_valid <= 1'b0;
      if (pop) begin
        cur_cmd <= head_cmd;
        cur_a   <= head_a;
        cur_b   <= head_b;
        cur_tag <= head_tag;
      end
      if (state == ST_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                  wait_cnt <= '0;
      if ((state == ST_WAIT && state_n == ST_IDLE) || reject) gap_cnt <= GAP_LOAD;
      else if (state == ST_IDLE && gap_cnt != '0)           gap_cnt <= gap_cnt - GAP_W'(1);
      // A response arriving on the last wait cycle takes priority over the local timeout.
      if (state == ST_WAIT && (resp_seen || timeout_hit)) begin
        res_valid <= 1'b1;
        res_tag   <= cur_tag;
        if (resp_seen) begin
          res_resp <= out_resp;
          res_data <= (out_resp == RESP_OK) ? out_data : '0;
        end else begin
          res_resp <= RESP_TIMEOUT;
          res_data <= '0;
        end
      end
      if (reject) begin
        res_valid <= 1'b1;
        res_resp  <= RESP_ERR;
        res_data  <= '0;
        res_tag   <= head_tag;
      end
      if (state != ST_WAIT && resp_seen) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed self-checking bench for calc1_port_driver with a small calc1 port responder.
// Expectations for cmd=3 follow CALC1_DRV_CMD_FILTER_EN when it is defined for the build.
module tb_calc1_port_driver;

  localparam int TIMEOUT_CYC = 64;
  localparam int STUB_LAT    = 2;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [3:0]  tag;
  } res_t;

  logic        c_clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_tag;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        res_valid;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic        err_spurious;

  logic        stub_mute;
  logic [1:0]  force_resp;
  logic [31:0] force_data;
  res_t        res_q[$];
  int          checks;
  int          passes;

  calc1_port_driver #(
    .FIFO_DEPTH  (4),
    .TAG_W       (4),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .GAP_CYC     (1)
  ) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_cmd       (op_cmd),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_tag       (op_tag),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .out_resp     (out_resp),
    .out_data     (out_data),
    .res_valid    (res_valid),
    .res_resp     (res_resp),
    .res_data     (res_data),
    .res_tag      (res_tag),
    .err_spurious (err_spurious)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // calc1 port stand-in: captures cmd/a then b, answers STUB_LAT cycles later; muted mode drives force_*.
  initial begin
    logic [3:0]  s_cmd;
    logic [31:0] s_a, s_b, r_data;
    logic [32:0] sum;
    logic [1:0]  r_resp;
    logic        exp_b;
    int          cnt;
    exp_b = 1'b0; cnt = 0; s_cmd = '0; s_a = '0; s_b = '0; r_data = '0; r_resp = '0; sum = '0;
    out_resp = 2'd0; out_data = 32'd0;
    forever begin
      @(posedge c_clk); #2;
      if (stub_mute) begin
        exp_b = 1'b0; cnt = 0;
        out_resp = force_resp; out_data = force_data;
      end else begin
        out_resp = 2'd0; out_data = 32'd0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin out_resp = r_resp; out_data = r_data; end
        end
        if (exp_b) begin
          s_b = req_data_out; exp_b = 1'b0; cnt = STUB_LAT;
          r_resp = 2'd1; r_data = 32'd0;
          case (s_cmd)
            4'd1: begin sum = {1'b0, s_a} + {1'b0, s_b}; r_data = sum[31:0]; if (sum[32]) r_resp = 2'd2; end
            4'd2: begin r_data = s_a - s_b; if (s_a < s_b) r_resp = 2'd2; end
            4'd5: r_data = s_a << s_b[4:0];
            4'd6: r_data = s_a >> s_b[4:0];
            default: r_resp = 2'd2;
          endcase
          if (r_resp != 2'd1) r_data = 32'hDEAD_BEEF;
        end else if (req_cmd_out != 4'd0) begin
          s_cmd = req_cmd_out; s_a = req_data_out; exp_b = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge c_clk); #1;
      if (res_valid) res_q.push_back('{resp: res_resp, data: res_data, tag: res_tag});
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge c_clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
    res_q.delete();
  endtask

  task automatic push_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n;
    n = 0;
    op_valid = 1'b1; op_cmd = cmd; op_a = a; op_b = b; op_tag = tag;
    while (!op_ready && n < 200) begin tick(); n++; end
    tick();
    op_valid = 1'b0;
    checks++; if (n >= 200) $display("[TB] FAIL push_accept: op_ready=%0b, required 1", op_ready); else passes++;
  endtask

  task automatic wait_results(input int want);
    int n;
    n = 0;
    while (res_q.size() < want && n < 400) begin tick(); n++; end
    checks++; if (res_q.size() < want) $display("[TB] FAIL result_count: got %0d results, required %0d", res_q.size(), want); else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (req_cmd_out !== 4'd0) $display("[TB] FAIL reset_cmd: got %h required 0", req_cmd_out); else passes++;
    checks++; if (req_data_out !== 32'd0) $display("[TB] FAIL reset_data: got %h required 0", req_data_out); else passes++;
    checks++; if (res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b required 0", res_valid); else passes++;
    checks++; if ({res_resp, res_data, res_tag} !== 38'd0) $display("[TB] FAIL reset_res: got %h/%h/%h required 0", res_resp, res_data, res_tag); else passes++;
    checks++; if (err_spurious !== 1'b0) $display("[TB] FAIL reset_err: got %b required 0", err_spurious); else passes++;
    checks++; if (op_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b required 1", op_ready); else passes++;
  endtask

  task automatic test_add();
    idle(3);
    push_op(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 4'h5);
    tick();
    checks++; if (req_cmd_out !== 4'd1) $display("[TB] FAIL add_send_a_cmd: got %h required 1", req_cmd_out); else passes++;
    checks++; if (req_data_out !== 32'h1) $display("[TB] FAIL add_send_a_data: got %h required 1", req_data_out); else passes++;
    tick();
    checks++; if (req_cmd_out !== 4'd0) $display("[TB] FAIL add_send_b_cmd: got %h required 0", req_cmd_out); else passes++;
    checks++; if (req_data_out !== 32'h01FF_FFFF) $display("[TB] FAIL add_send_b_data: got %h required 01ffffff", req_data_out); else passes++;
    tick();
    checks++; if ({req_cmd_out, req_data_out} !== 36'd0) $display("[TB] FAIL add_wait_bus: got %h/%h required 0/0", req_cmd_out, req_data_out); else passes++;
    wait_results(1);
    checks++; if (res_q[0].resp !== 2'd1) $display("[TB] FAIL add_resp: got %0d required 1", res_q[0].resp); else passes++;
    checks++; if (res_q[0].data !== 32'h0200_0000) $display("[TB] FAIL add_data: got %h required 02000000", res_q[0].data); else passes++;
    checks++; if (res_q[0].tag !== 4'h5) $display("[TB] FAIL add_tag: got %h required 5", res_q[0].tag); else passes++;
  endtask

  task automatic test_error();
    idle(5);
    push_op(4'd1, 32'hFFFF_FFFF, 32'h1, 4'h2);
    wait_results(1);
    checks++; if (res_q[0].resp !== 2'd2) $display("[TB] FAIL ovf_resp: got %0d required 2", res_q[0].resp); else passes++;
    checks++; if (res_q[0].data !== 32'd0) $display("[TB] FAIL ovf_data: got %h required 0", res_q[0].data); else passes++;
    idle(5);
    push_op(4'd2, 32'h1, 32'hF, 4'h3);
    wait_results(1);
    checks++; if (res_q[0].resp !== 2'd2) $display("[TB] FAIL sub_resp: got %0d required 2", res_q[0].resp); else passes++;
    checks++; if (res_q[0].data !== 32'd0 || res_q[0].tag !== 4'h3) $display("[TB] FAIL sub_data_tag: got %h/%h required 0/3", res_q[0].data, res_q[0].tag); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cmds[5];
    logic [31:0] as[5], bs[5], exp_data[5];
    cmds = '{4'd1, 4'd1, 4'd2, 4'd5, 4'd6};
    as   = '{32'd2, 32'd10, 32'd9, 32'd1, 32'hF0};
    bs   = '{32'd3, 32'd20, 32'd4, 32'd4, 32'd4};
    exp_data = '{32'd5, 32'd30, 32'd5, 32'h10, 32'hF};
    idle(5);
    for (int i = 0; i < 5; i++) push_op(cmds[i], as[i], bs[i], 4'(i + 1));
    checks++; if (op_ready !== 1'b0) $display("[TB] FAIL full_ready: got %b required 0", op_ready); else passes++;
    wait_results(5);
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_q[i].resp !== 2'd1) $display("[TB] FAIL b2b_resp%0d: got %0d required 1", i, res_q[i].resp); else passes++;
      checks++; if (res_q[i].data !== exp_data[i]) $display("[TB] FAIL b2b_data%0d: got %h required %h", i, res_q[i].data, exp_data[i]); else passes++;
      checks++; if (res_q[i].tag !== 4'(i + 1)) $display("[TB] FAIL b2b_tag%0d: got %h required %h", i, res_q[i].tag, 4'(i + 1)); else passes++;
    end
  endtask

  task automatic test_timeout();
    int n;
    idle(5);
    stub_mute = 1'b1; force_resp = 2'd0; force_data = 32'd0;
    push_op(4'd1, 32'd1, 32'd1, 4'h9);
    repeat (3) tick();
    n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    checks++; if (n !== TIMEOUT_CYC) $display("[TB] FAIL timeout_latency: got %0d cycles required %0d", n, TIMEOUT_CYC); else passes++;
    checks++; if (res_resp !== 2'd3 || res_data !== 32'd0) $display("[TB] FAIL timeout_result: got %0d/%h required 3/0", res_resp, res_data); else passes++;
    checks++; if (res_tag !== 4'h9) $display("[TB] FAIL timeout_tag: got %h required 9", res_tag); else passes++;
    checks++; if (err_spurious !== 1'b0) $display("[TB] FAIL err_before_late: got %b required 0", err_spurious); else passes++;
    force_resp = 2'd1; force_data = 32'h1234;
    tick();
    force_resp = 2'd0; force_data = 32'd0;
    repeat (3) tick();
    checks++; if (err_spurious !== 1'b1) $display("[TB] FAIL late_resp_err: got %b required 1", err_spurious); else passes++;
    checks++; if (res_q.size() !== 1) $display("[TB] FAIL late_resp_no_result: got %0d results required 1", res_q.size()); else passes++;
  endtask

  task automatic test_timeout_race();
    idle(5);
    push_op(4'd1, 32'd1, 32'd1, 4'hB);
    repeat (3) tick();
    repeat (TIMEOUT_CYC - 1) tick();
    checks++; if (res_valid !== 1'b0) $display("[TB] FAIL race_early: got res_valid %b required 0", res_valid); else passes++;
    force_resp = 2'd1; force_data = 32'h55;
    tick();
    force_resp = 2'd0; force_data = 32'd0;
    checks++; if (res_valid !== 1'b1 || res_resp !== 2'd1) $display("[TB] FAIL race_resp: got %b/%0d required 1/1", res_valid, res_resp); else passes++;
    checks++; if (res_data !== 32'h55 || res_tag !== 4'hB) $display("[TB] FAIL race_data: got %h/%h required 55/b", res_data, res_tag); else passes++;
    repeat (3) tick();
    checks++; if (res_q.size() !== 1) $display("[TB] FAIL race_single: got %0d results required 1", res_q.size()); else passes++;
  endtask

  task automatic test_reset_mid_op();
    logic activity;
    idle(5);
    push_op(4'd1, 32'd3, 32'd4, 4'h9);
    push_op(4'd1, 32'd5, 32'd6, 4'hA);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({req_cmd_out, req_data_out} !== 36'd0) $display("[TB] FAIL rst_mid_bus: got %h/%h required 0/0", req_cmd_out, req_data_out); else passes++;
    checks++; if (err_spurious !== 1'b0) $display("[TB] FAIL rst_mid_err: got %b required 0", err_spurious); else passes++;
    checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) $display("[TB] FAIL rst_mid_flags: got ready %b valid %b required 1/0", op_ready, res_valid); else passes++;
    stub_mute = 1'b0;
    activity = 1'b0;
    repeat (10) begin
      tick();
      if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0 || res_valid !== 1'b0) activity = 1'b1;
    end
    checks++; if (activity !== 1'b0) $display("[TB] FAIL rst_mid_queue_empty: got activity %b required 0", activity); else passes++;
    push_op(4'd1, 32'd7, 32'd8, 4'h3);
    wait_results(1);
    checks++; if (res_q[0].resp !== 2'd1 || res_q[0].data !== 32'd15) $display("[TB] FAIL rst_mid_next: got %0d/%h required 1/f", res_q[0].resp, res_q[0].data); else passes++;
    checks++; if (res_q[0].tag !== 4'h3) $display("[TB] FAIL rst_mid_next_tag: got %h required 3", res_q[0].tag); else passes++;
  endtask

  task automatic test_cmd3();
    logic activity;
    idle(5);
    push_op(4'd3, 32'd5, 32'd6, 4'h7);
`ifdef CALC1_DRV_CMD_FILTER_EN
    activity = 1'b0;
    repeat (10) begin
      tick();
      if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0) activity = 1'b1;
    end
    checks++; if (activity !== 1'b0) $display("[TB] FAIL cmd3_bus_quiet: got activity %b required 0", activity); else passes++;
`else
    tick();
    activity = (req_cmd_out === 4'd3) && (req_data_out === 32'd5);
    checks++; if (activity !== 1'b1) $display("[TB] FAIL cmd3_send_a: got %h/%h required 3/5", req_cmd_out, req_data_out); else passes++;
    tick();
    checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'd6) $display("[TB] FAIL cmd3_send_b: got %h/%h required 0/6", req_cmd_out, req_data_out); else passes++;
`endif
    wait_results(1);
    checks++; if (res_q[0].resp !== 2'd2 || res_q[0].data !== 32'd0) $display("[TB] FAIL cmd3_result: got %0d/%h required 2/0", res_q[0].resp, res_q[0].data); else passes++;
    checks++; if (res_q[0].tag !== 4'h7) $display("[TB] FAIL cmd3_tag: got %h required 7", res_q[0].tag); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0;
    reset = 1'b1; op_valid = 1'b0; op_cmd = '0; op_a = '0; op_b = '0; op_tag = '0;
    stub_mute = 1'b0; force_resp = 2'd0; force_data = 32'd0;
    test_reset();
    test_add();
    test_error();
    test_back_to_back();
    test_timeout();
    test_timeout_race();
    test_reset_mid_op();
    test_cmd3();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
